// File: rtl/vec_reg_file.sv
// Scalar + vector register file with combinational write-through reads and a
// per-register busy scoreboard that drives the issue stall.
module vec_reg_file #(
    parameter int LANES = 16,
    parameter int WIDTH = 32,
    parameter int NREG  = 16,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic                   w_vsel,
    input  logic [AW-1:0]          wa,
    input  logic [LANES*WIDTH-1:0] wd,
    input  logic [LANES-1:0]       wmask,
    input  logic                   r_vsel,
    input  logic [AW-1:0]          ra1,
    input  logic [AW-1:0]          ra2,
    input  logic [WIDTH-1:0]       pc,
    output logic [LANES*WIDTH-1:0] rd1,
    output logic [LANES*WIDTH-1:0] rd2,
    input  logic                   iss_valid,
    input  logic                   iss_vsel,
    input  logic [AW-1:0]          iss_dst,
    input  logic [AW-1:0]          iss_src1,
    input  logic [AW-1:0]          iss_src2,
    output logic                   stall
);

    localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);
    localparam int TOP = (LANES - 1) * WIDTH;

    typedef logic [WIDTH-1:0] word_t;

    word_t           sreg [NREG-1];
    word_t           vreg [NREG][LANES];
    logic [NREG-1:0] busy [2];
    logic [NREG-1:0] iss_busy;
    logic            accept;

    // Scalar values live in the top lane; PC index bypasses the array entirely.
    function automatic logic [LANES*WIDTH-1:0] read_port(input logic [AW-1:0] idx);
        logic [LANES*WIDTH-1:0] v;
        v = '0;
        if (r_vsel) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (we && w_vsel && (wa == idx) && wmask[l])
                    v[l*WIDTH +: WIDTH] = wd[l*WIDTH +: WIDTH];
                else
                    v[l*WIDTH +: WIDTH] = vreg[idx][l];
            end
        end else if (idx == PC_IDX) begin
            v[TOP +: WIDTH] = pc;
        end else if (we && !w_vsel && (wa == idx)) begin
            v[TOP +: WIDTH] = wd[TOP +: WIDTH];
        end else begin
            v[TOP +: WIDTH] = sreg[idx];
        end
        if (rst && !(!r_vsel && (idx == PC_IDX)))
            v = '0;
        return v;
    endfunction

    always_comb rd1 = read_port(ra1);
    always_comb rd2 = read_port(ra2);

    // A register retiring this cycle no longer blocks issue.
    always_comb begin
        iss_busy = busy[iss_vsel];
        if (we && (w_vsel == iss_vsel))
            iss_busy[wa] = 1'b0;
        stall = 1'b0;
        if (iss_valid && !rst)
            stall = iss_busy[iss_src1] | iss_busy[iss_src2] | iss_busy[iss_dst];
    end

    assign accept = iss_valid & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG - 1; r++)
                sreg[r] <= '0;
            for (int unsigned r = 0; r < NREG; r++)
                for (int unsigned l = 0; l < LANES; l++)
                    vreg[r][l] <= '0;
            busy[0] <= '0;
            busy[1] <= '0;
        end else begin
            if (we && !w_vsel && (wa != PC_IDX))
                sreg[wa] <= wd[TOP +: WIDTH];
            if (we && w_vsel)
                for (int unsigned l = 0; l < LANES; l++)
                    if (wmask[l])
                        vreg[wa][l] <= wd[l*WIDTH +: WIDTH];
            // Clear first so a same-cycle issue to the same register wins.
            if (we)
                busy[w_vsel][wa] <= 1'b0;
            if (accept && !(!iss_vsel && (iss_dst == PC_IDX)))
                busy[iss_vsel][iss_dst] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed + randomized bench for vec_reg_file against a behavioural model
// of register contents and per-register busy flags.
module tb_vec_reg_file;

    localparam int LANES = 16;
    localparam int WIDTH = 32;
    localparam int NREG  = 16;
    localparam int AW    = 4;
    localparam int DW    = LANES * WIDTH;
    localparam int TOP   = (LANES - 1) * WIDTH;

    logic          clk = 1'b0;
    logic          rst, we, w_vsel, r_vsel, iss_valid, iss_vsel, stall;
    logic [AW-1:0] wa, ra1, ra2, iss_dst, iss_src1, iss_src2;
    logic [DW-1:0] wd, rd1, rd2;
    logic [LANES-1:0] wmask;
    logic [WIDTH-1:0] pc;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_s [NREG];
    logic [WIDTH-1:0] m_v [NREG][LANES];
    bit               m_busy [2][NREG];

    vec_reg_file #(.LANES(LANES), .WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .we(we), .w_vsel(w_vsel), .wa(wa), .wd(wd),
        .wmask(wmask), .r_vsel(r_vsel), .ra1(ra1), .ra2(ra2), .pc(pc),
        .rd1(rd1), .rd2(rd2), .iss_valid(iss_valid), .iss_vsel(iss_vsel),
        .iss_dst(iss_dst), .iss_src1(iss_src1), .iss_src2(iss_src2), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_rd(input int idx);
        logic [DW-1:0] v = '0;
        if (!r_vsel && idx == NREG - 1) begin
            v[TOP +: WIDTH] = pc;
        end else if (!rst) begin
            if (r_vsel) begin
                for (int l = 0; l < LANES; l++)
                    v[l*WIDTH +: WIDTH] = (we && w_vsel && int'(wa) == idx && wmask[l])
                                          ? wd[l*WIDTH +: WIDTH] : m_v[idx][l];
            end else begin
                v[TOP +: WIDTH] = (we && !w_vsel && int'(wa) == idx) ? wd[TOP +: WIDTH] : m_s[idx];
            end
        end
        return v;
    endfunction

    function automatic bit reg_blocked(input int r);
        if (we && w_vsel == iss_vsel && int'(wa) == r) return 1'b0;
        return m_busy[iss_vsel][r];
    endfunction

    function automatic logic exp_stall();
        if (rst || !iss_valid) return 1'b0;
        return reg_blocked(int'(iss_src1)) || reg_blocked(int'(iss_src2)) || reg_blocked(int'(iss_dst));
    endfunction

    function automatic void model_update();
        bit acc;
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_s[r] = '0;
                m_busy[0][r] = 1'b0;
                m_busy[1][r] = 1'b0;
                for (int l = 0; l < LANES; l++) m_v[r][l] = '0;
            end
            return;
        end
        acc = iss_valid && !exp_stall();
        if (we && !w_vsel && int'(wa) != NREG - 1) m_s[wa] = wd[TOP +: WIDTH];
        if (we && w_vsel)
            for (int l = 0; l < LANES; l++)
                if (wmask[l]) m_v[wa][l] = wd[l*WIDTH +: WIDTH];
        if (we) m_busy[w_vsel][wa] = 1'b0;
        if (acc && !(!iss_vsel && int'(iss_dst) == NREG - 1)) m_busy[iss_vsel][iss_dst] = 1'b1;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic settle();
        #1;
        check("rd1", rd1, exp_rd(int'(ra1)));
        check("rd2", rd2, exp_rd(int'(ra2)));
        check("stall", {{(DW-1){1'b0}}, stall}, {{(DW-1){1'b0}}, exp_stall()});
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; we = 0; w_vsel = 0; wa = '0; wd = '0; wmask = '0;
        r_vsel = 0; ra1 = '0; ra2 = '0; iss_valid = 0; iss_vsel = 0;
        iss_dst = '0; iss_src1 = '0; iss_src2 = '0;
    endtask

    task automatic issue(input logic vs, input int d, input int s1, input int s2);
        iss_valid = 1; iss_vsel = vs;
        iss_dst = AW'(d); iss_src1 = AW'(s1); iss_src2 = AW'(s2);
    endtask

    function automatic int rnd_idx();
        return ($urandom_range(0, 4) == 0) ? NREG - 1 : int'($urandom_range(0, 6));
    endfunction

    logic [DW-1:0] expv;

    initial begin
        idle();
        pc = 32'h100;
        for (int r = 0; r < NREG; r++) begin
            m_s[r] = 'x; m_busy[0][r] = 0; m_busy[1][r] = 0;
            for (int l = 0; l < LANES; l++) m_v[r][l] = 'x;
        end
        @(posedge clk); #1;

        // Reset with a competing write and issue.
        rst = 1; we = 1; w_vsel = 1; wa = 3; wmask = '1; wd = {LANES{32'hA5A5A5A5}};
        issue(1, 2, 0, 0); r_vsel = 0; ra1 = 15; ra2 = 3;
        settle(); tick();
        r_vsel = 1; settle(); tick();
        idle();
        r_vsel = 1; ra1 = 3; ra2 = 9; settle();
        check("reset_v3", rd1, '0);
        tick();

        // Masked vector write with write-through on the same index.
        we = 1; w_vsel = 1; wa = 3; wmask = 16'h00FF;
        for (int l = 0; l < LANES; l++) wd[l*WIDTH +: WIDTH] = l;
        r_vsel = 1; ra1 = 3; ra2 = 4;
        settle(); tick();
        idle(); r_vsel = 1; ra1 = 3;
        expv = '0;
        for (int l = 0; l < 8; l++) expv[l*WIDTH +: WIDTH] = l;
        settle();
        check("vmask_v3", rd1, expv);
        tick();

        // Scalar write to the PC index is discarded.
        we = 1; w_vsel = 0; wa = 15; wd = '0; wd[TOP +: WIDTH] = 32'h55;
        r_vsel = 0; ra1 = 15; ra2 = 0;
        settle();
        expv = '0; expv[TOP +: WIDTH] = 32'h100;
        check("pc_read", rd1, expv);
        tick();
        idle(); ra1 = 15; ra2 = 14; settle();
        check("pc_read_after", rd1, expv);
        tick();

        // Scalar write-through.
        we = 1; w_vsel = 0; wa = 2; wd = {LANES{32'h1234}}; wd[TOP +: WIDTH] = 32'hDEAD;
        r_vsel = 0; ra1 = 2; ra2 = 3;
        settle();
        expv = '0; expv[TOP +: WIDTH] = 32'hDEAD;
        check("scalar_wt", rd1, expv);
        tick();

        // Hazard on vector 5, released by a same-cycle writeback.
        idle(); issue(1, 5, 0, 0); settle(); tick();
        issue(1, 6, 5, 6); settle();
        check("stall_raw5", {{(DW-1){1'b0}}, stall}, {{(DW-1){1'b0}}, 1'b1});
        tick();
        we = 1; w_vsel = 1; wa = 5; wmask = '0;
        settle();
        check("stall_wb5", {{(DW-1){1'b0}}, stall}, '0);
        tick();
        idle(); issue(1, 8, 5, 8); settle();
        check("busy5_clear", {{(DW-1){1'b0}}, stall}, '0);
        tick();

        // Issue and writeback to the same register: busy stays set.
        idle(); issue(1, 4, 0, 0); we = 1; w_vsel = 1; wa = 4; wmask = 16'h0001;
        wd = {LANES{32'hCAFE0004}};
        settle(); tick();
        idle(); issue(1, 9, 4, 0); settle();
        check("set_wins4", {{(DW-1){1'b0}}, stall}, {{(DW-1){1'b0}}, 1'b1});
        tick();

        // Reset clears loaded registers and busy bits.
        idle(); issue(0, 1, 0, 0); we = 1; w_vsel = 1; wa = 7; wmask = '1;
        wd = {LANES{32'h77777777}}; settle(); tick();
        idle(); issue(1, 7, 0, 0); settle(); tick();
        idle(); rst = 1; we = 1; w_vsel = 1; wa = 7; wmask = '1; issue(1, 7, 7, 7);
        r_vsel = 1; ra1 = 7; ra2 = 3;
        settle();
        check("rst_stall", {{(DW-1){1'b0}}, stall}, '0);
        tick();
        idle(); issue(1, 7, 7, 7); r_vsel = 1; ra1 = 7; ra2 = 4;
        settle();
        check("post_rst_v7", rd1, '0);
        check("post_rst_stall", {{(DW-1){1'b0}}, stall}, '0);
        tick();
        idle(); issue(0, 1, 1, 1); r_vsel = 0; ra1 = 1; settle(); tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 63) == 0);
            we = $urandom_range(0, 1);
            w_vsel = $urandom_range(0, 1);
            wa = AW'(rnd_idx());
            for (int l = 0; l < LANES; l++) wd[l*WIDTH +: WIDTH] = $urandom;
            wmask = LANES'($urandom);
            if ($urandom_range(0, 3) == 0) wmask = '0;
            r_vsel = $urandom_range(0, 1);
            ra1 = ($urandom_range(0, 2) == 0) ? wa : AW'(rnd_idx());
            ra2 = AW'(rnd_idx());
            pc = $urandom;
            if ($urandom_range(0, 2) != 0)
                issue($urandom_range(0, 1), rnd_idx(), rnd_idx(), rnd_idx());
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
